// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the PicoRV32 native memory bus; a grant is held for one whole transfer.
// Define ARB_TIMEOUT_EN to add the slave-response timeout with its sticky err flag.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ready,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                grant,
  output logic                busy,
  output logic                err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state;
  logic   grant_q;
  logic   last_q;
  logic   gnt_valid;
  logic   sel_m1;
  logic   to_hit;
  logic   xfer_end;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("TIMEOUT must fit the 8-bit response counter");
  end

  assign busy      = (state == BUSY);
  assign grant     = grant_q;
  assign gnt_valid = grant_q ? m1_valid : m0_valid;
  assign s_valid   = busy & gnt_valid;

  // Idle parks the slave-side mux on m0; its contents are don't-care while s_valid is low.
  assign sel_m1  = busy & grant_q;
  assign s_addr  = sel_m1 ? m1_addr  : m0_addr;
  assign s_wdata = sel_m1 ? m1_wdata : m0_wdata;
  assign s_wstrb = sel_m1 ? m1_wstrb : m0_wstrb;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] to_cnt;
  logic       err_q;

  // Fires on the TIMEOUT-th busy cycle; a coincident s_ready takes precedence.
  assign to_hit = s_valid & ~s_ready & (to_cnt == TO_LAST);
  assign err    = err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (!busy)
        to_cnt <= '0;
      else if (!s_ready)
        to_cnt <= to_cnt + 8'd1;
      if (to_hit)
        err_q <= 1'b1;
    end
  end

  assign m0_rdata = to_hit ? DATA_W'(32'hDEAD_BEEF) : s_rdata;
  assign m1_rdata = to_hit ? DATA_W'(32'hDEAD_BEEF) : s_rdata;
`else
  assign to_hit   = 1'b0;
  assign err      = 1'b0;
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
`endif

  // Gating with s_valid keeps an aborted transfer from ever pulsing ready.
  assign xfer_end = (s_valid & s_ready) | to_hit;
  assign m0_ready = xfer_end & ~grant_q;
  assign m1_ready = xfer_end &  grant_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else if (state == IDLE) begin
      if (m0_valid && m1_valid) begin
        grant_q <= ~last_q;
        state   <= BUSY;
      end else if (m0_valid) begin
        grant_q <= 1'b0;
        state   <= BUSY;
      end else if (m1_valid) begin
        grant_q <= 1'b1;
        state   <= BUSY;
      end
    end else begin
      // A dropped request abandons the transfer without touching round-robin history.
      if (!gnt_valid) begin
        state <= IDLE;
      end else if (xfer_end) begin
        last_q <= grant_q;
        state  <= IDLE;
      end
    end
  end

endmodule
